// File: rtl/persistencia_pkg.sv
// Shared types and helpers for the multi-channel persistence filter.
package persistencia_pkg;

  typedef enum logic [1:0] {
    NORMAL       = 2'd0,
    SOSPECHA     = 2'd1,
    ALARMA       = 2'd2,
    RECUPERACION = 2'd3
  } estado_t;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/persistencia_canal.sv
// One persistence channel: hysteresis FSM, run counter, event pulse and sticky alarm.
module persistencia_canal
  import persistencia_pkg::*;
#(
  parameter int          N_ACT    = 5,
  parameter int          N_DESACT = 3,
  parameter int unsigned CW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          muestra_valida,
  input  logic          fuera_rango,
  input  logic          limpiar,
  output logic          persistencia,
  output logic          evento,
  output logic          alarma_sticky,
  output logic [CW-1:0] contador
);

  estado_t       estado, estado_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          evento_n;
  logic          sticky;

  assign cnt_inc = cnt + CW'(1);

  // State, counter, event and sticky registers
  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= NORMAL;
      cnt    <= '0;
      evento <= 1'b0;
      sticky <= 1'b0;
    end else begin
      estado <= estado_n;
      cnt    <= cnt_n;
      evento <= evento_n;
      // Set has priority over clear when both land on the same edge
      if (evento_n)     sticky <= 1'b1;
      else if (limpiar) sticky <= 1'b0;
    end
  end

  // Next-state, counter and event decode
  always_comb begin
    estado_n = estado;
    cnt_n    = cnt;
    evento_n = 1'b0;
    case (estado)
      NORMAL: begin
        if (muestra_valida && fuera_rango) begin
          if (N_ACT == 1) begin
            estado_n = ALARMA;
            cnt_n    = '0;
            evento_n = 1'b1;
          end else begin
            estado_n = SOSPECHA;
            cnt_n    = CW'(1);
          end
        end
      end
      SOSPECHA: begin
        if (muestra_valida) begin
          if (fuera_rango) begin
            if (cnt_inc == CW'(N_ACT)) begin
              estado_n = ALARMA;
              cnt_n    = '0;
              evento_n = 1'b1;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            estado_n = NORMAL;
            cnt_n    = '0;
          end
        end
      end
      ALARMA: begin
        if (muestra_valida && !fuera_rango) begin
          if (N_DESACT == 1) begin
            estado_n = NORMAL;
            cnt_n    = '0;
          end else begin
            estado_n = RECUPERACION;
            cnt_n    = CW'(1);
          end
        end
      end
      RECUPERACION: begin
        if (muestra_valida) begin
          if (!fuera_rango) begin
            if (cnt_inc == CW'(N_DESACT)) begin
              estado_n = NORMAL;
              cnt_n    = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            // Bounce back into alarm without a fresh event
            estado_n = ALARMA;
            cnt_n    = '0;
          end
        end
      end
      default: begin
        estado_n = NORMAL;
        cnt_n    = '0;
      end
    endcase
  end

  // ALARMA and RECUPERACION both have bit 1 set, so the level is a register bit
  assign persistencia  = estado[1];
  assign alarma_sticky = sticky;
  assign contador      = cnt;

endmodule

// File: rtl/persistencia_multi.sv
// Multi-channel persistence filter with hysteresis, sticky alarms and event pulses.
module persistencia_multi
  import persistencia_pkg::*;
#(
  parameter int CANALES  = 4,
  parameter int N_ACT    = 5,
  parameter int N_DESACT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  muestra_valida,
  input  logic [CANALES-1:0]    fuera_rango,
  input  logic [CANALES-1:0]    limpiar,
  output logic [CANALES-1:0]    persistencia,
  output logic [CANALES-1:0]    evento,
  output logic [CANALES-1:0]    alarma_sticky,
  output logic                  alguna_alarma,
  output logic [CANALES*CW-1:0] contador
);

  localparam int unsigned CW = $clog2(max_int(N_ACT, N_DESACT) + 1);

  // Reject meaningless configurations at elaboration
  if (CANALES < 1) begin : g_err_canales
    $error("persistencia_multi: CANALES must be >= 1");
  end
  if (N_ACT < 1) begin : g_err_act
    $error("persistencia_multi: N_ACT must be >= 1");
  end
  if (N_DESACT < 1) begin : g_err_desact
    $error("persistencia_multi: N_DESACT must be >= 1");
  end

  // One independent filter per channel
  for (genvar i = 0; i < CANALES; i++) begin : g_canal
    persistencia_canal #(
      .N_ACT    (N_ACT),
      .N_DESACT (N_DESACT),
      .CW       (CW)
    ) u_canal (
      .clk            (clk),
      .rst            (rst),
      .muestra_valida (muestra_valida),
      .fuera_rango    (fuera_rango[i]),
      .limpiar        (limpiar[i]),
      .persistencia   (persistencia[i]),
      .evento         (evento[i]),
      .alarma_sticky  (alarma_sticky[i]),
      .contador       (contador[i*CW +: CW])
    );
  end

  assign alguna_alarma = |alarma_sticky;

endmodule
